// File: rtl/tl_ul_link_buffer.sv
// tl_ul_link_buffer: registered TileLink-UL link buffer feeding the link monitor.
// Ports:
//   clock, reset_n             - clock, asynchronous active-low reset
//   in_a_* / out_a_*           - A channel (master -> slave), 83-bit payload, 2-entry queue
//   in_d_* / out_d_*           - D channel (slave -> master), 50-bit payload, 2-entry queue
//   inflight                   - A beats issued downstream and not yet answered by D
//   idle                       - both queues empty and nothing in flight
//   err_underflow              - sticky, D accepted while inflight was zero

// 2-entry queue with the head held in its own register (slot0) so the output
// bits come straight from a flop; ready depends on registered occupancy only.
module tl_ul_link_fifo #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_bits,
    input  logic         pop,
    output logic         nonempty,
    output logic [W-1:0] head
);
    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic         push;

    assign in_ready = (cnt_q < 2'd2);
    assign push     = in_valid && in_ready;
    assign nonempty = (cnt_q != 2'd0);
    assign head     = slot0_q;

    // Slot update: pop shifts slot1 forward, push lands in the first free slot.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q + 2'(push) - 2'(pop);
        if (pop && (cnt_q == 2'd2)) begin
            slot0_d = slot1_q;
        end
        if (push) begin
            if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
                slot0_d = in_bits;
            end else begin
                slot1_d = in_bits;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end
endmodule

module tl_ul_link_buffer #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_a_valid,
    output logic             in_a_ready,
    input  logic [82:0]      in_a_bits,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [82:0]      out_a_bits,
    input  logic             in_d_valid,
    output logic             in_d_ready,
    input  logic [49:0]      in_d_bits,
    output logic             out_d_valid,
    input  logic             out_d_ready,
    output logic [49:0]      out_d_bits,
    output logic [CNT_W-1:0] inflight,
    output logic             idle,
    output logic             err_underflow
);
    localparam int unsigned A_W = 83;
    localparam int unsigned D_W = 50;

    logic             a_nonempty, d_nonempty;
    logic             a_out_fire, d_out_fire, d_in_fire;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;

    // Throttle only gates the head; it cannot drop while valid because only
    // an A fire raises the count.
    assign out_a_valid = a_nonempty && (inflight_q < CNT_W'(MAX_INFLIGHT));
    assign a_out_fire  = out_a_valid && out_a_ready;
    assign out_d_valid = d_nonempty;
    assign d_out_fire  = out_d_valid && out_d_ready;
    assign d_in_fire   = in_d_valid && in_d_ready;

    tl_ul_link_fifo #(.W(A_W)) u_a_q (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_a_valid),
        .in_ready (in_a_ready),
        .in_bits  (in_a_bits),
        .pop      (a_out_fire),
        .nonempty (a_nonempty),
        .head     (out_a_bits)
    );

    tl_ul_link_fifo #(.W(D_W)) u_d_q (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_d_valid),
        .in_ready (in_d_ready),
        .in_bits  (in_d_bits),
        .pop      (d_out_fire),
        .nonempty (d_nonempty),
        .head     (out_d_bits)
    );

    // In-flight accounting; a D with nothing outstanding saturates at zero and flags.
    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (d_in_fire && (inflight_q == '0)) begin
            err_d = 1'b1;
        end
        if (a_out_fire && !d_in_fire) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (d_in_fire && !a_out_fire && (inflight_q != '0)) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign inflight      = inflight_q;
    assign err_underflow = err_q;
    assign idle          = !a_nonempty && !d_nonempty && (inflight_q == '0);
endmodule

// File: tb/tb_tl_ul_link_buffer.sv
// Testbench for tl_ul_link_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based transaction model.
module tb_tl_ul_link_buffer;
    localparam int unsigned MAX = 4;
    localparam int unsigned CW  = 8;

    logic          clock;
    logic          reset_n;
    logic          in_a_valid, in_a_ready, out_a_valid, out_a_ready;
    logic [82:0]   in_a_bits, out_a_bits;
    logic          in_d_valid, in_d_ready, out_d_valid, out_d_ready;
    logic [49:0]   in_d_bits, out_d_bits;
    logic [CW-1:0] inflight;
    logic          idle, err_underflow;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queues and an integer outstanding count.
    logic [82:0] aq[$];
    logic [49:0] dq[$];
    int          infl;
    bit          err;

    tl_ul_link_buffer #(.MAX_INFLIGHT(MAX), .CNT_W(CW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_a_valid    (in_a_valid),
        .in_a_ready    (in_a_ready),
        .in_a_bits     (in_a_bits),
        .out_a_valid   (out_a_valid),
        .out_a_ready   (out_a_ready),
        .out_a_bits    (out_a_bits),
        .in_d_valid    (in_d_valid),
        .in_d_ready    (in_d_ready),
        .in_d_bits     (in_d_bits),
        .out_d_valid   (out_d_valid),
        .out_d_ready   (out_d_ready),
        .out_d_bits    (out_d_bits),
        .inflight      (inflight),
        .idle          (idle),
        .err_underflow (err_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [82:0] got, input logic [82:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_check();
        bit m_av;
        m_av = (aq.size() > 0) && (infl < int'(MAX));
        chk("a_ready", 83'(in_a_ready), 83'(aq.size() < 2));
        chk("a_valid", 83'(out_a_valid), 83'(m_av));
        if (m_av) chk("a_bits", out_a_bits, aq[0]);
        chk("d_ready", 83'(in_d_ready), 83'(dq.size() < 2));
        chk("d_valid", 83'(out_d_valid), 83'(dq.size() > 0));
        if (dq.size() > 0) chk("d_bits", 83'(out_d_bits), 83'(dq[0]));
        chk("inflight", 83'(inflight), 83'(infl));
        chk("idle", 83'(idle), 83'((aq.size() == 0) && (dq.size() == 0) && (infl == 0)));
        chk("err", 83'(err_underflow), 83'(err));
    endtask

    // Drive one cycle of inputs, advance the model with the same inputs, then compare.
    task automatic step(input logic av, input logic [82:0] ab, input logic ar,
                        input logic dv, input logic [49:0] db, input logic dr);
        bit a_in, a_out, d_in, d_out;
        in_a_valid  = av;
        in_a_bits   = ab;
        out_a_ready = ar;
        in_d_valid  = dv;
        in_d_bits   = db;
        out_d_ready = dr;
        a_in  = av && (aq.size() < 2);
        a_out = (aq.size() > 0) && (infl < int'(MAX)) && ar;
        d_in  = dv && (dq.size() < 2);
        d_out = (dq.size() > 0) && dr;
        @(posedge clock);
        if (a_out) void'(aq.pop_front());
        if (a_in)  aq.push_back(ab);
        if (d_out) void'(dq.pop_front());
        if (d_in)  dq.push_back(db);
        if (d_in && infl == 0) err = 1'b1;
        if (a_out && !d_in) infl++;
        else if (d_in && !a_out && infl > 0) infl--;
        #1;
        model_check();
    endtask

    task automatic model_reset();
        aq.delete();
        dq.delete();
        infl = 0;
        err  = 1'b0;
    endtask

    task automatic drive_idle();
        in_a_valid  = 1'b0;
        in_a_bits   = '0;
        out_a_ready = 1'b0;
        in_d_valid  = 1'b0;
        in_d_bits   = '0;
        out_d_ready = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic logic [82:0] rand_a();
        return 83'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [49:0] rand_d();
        return 50'({$urandom(), $urandom()});
    endfunction

    logic [82:0] get_beat;
    logic [49:0] ackd_beat;

    initial begin
        get_beat  = {3'd4, 3'd0, 4'd2, 7'h05, 30'h0000_1000, 4'hf, 32'h0};
        ackd_beat = {3'd1, 2'd0, 4'd2, 7'h05, 1'b0, 32'hdead_beef, 1'b0};
        drive_idle();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_a_bits", out_a_bits, 83'd0);
        chk("rst_d_bits", 83'(out_d_bits), 83'd0);
        model_check();
        @(negedge clock);
        reset_n = 1'b1;

        // Single Get: one-cycle latency, unchanged bits, then counted in flight.
        step(1'b1, get_beat, 1'b1, 1'b0, '0, 1'b0);
        chk("t1_valid", 83'(out_a_valid), 83'd1);
        chk("t1_bits", out_a_bits, get_beat);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("t1_infl", 83'(inflight), 83'd1);
        chk("t1_idle", 83'(idle), 83'd0);

        // Stall downstream, offer 3 beats, then drain in order.
        for (int i = 0; i < 3; i++) step(1'b1, rand_a(), 1'b0, 1'b0, '0, 1'b0);
        chk("t2_ready_low", 83'(in_a_ready), 83'd0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

        // Throttle at MAX_INFLIGHT, released by one D beat.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, rand_a(), 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("t3_infl_max", 83'(inflight), 83'(MAX));
        chk("t3_throttled", 83'(out_a_valid), 83'd0);
        step(1'b0, '0, 1'b1, 1'b1, ackd_beat, 1'b1);
        chk("t3_infl_dec", 83'(inflight), 83'(MAX - 1));
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        chk("t3_fifth_fire", 83'(inflight), 83'(MAX));

        // Simultaneous A fire and D accept at inflight 2.
        do_reset();
        step(1'b1, rand_a(), 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, rand_a(), 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, rand_a(), 1'b1, 1'b0, '0, 1'b0);
        chk("t4_pre", 83'(inflight), 83'd2);
        step(1'b0, '0, 1'b1, 1'b1, ackd_beat, 1'b1);
        chk("t4_same", 83'(inflight), 83'd2);

        // Underflow: flagged, sticky, count held at zero, beat still forwarded.
        do_reset();
        step(1'b0, '0, 1'b0, 1'b1, ackd_beat, 1'b0);
        chk("t5_err", 83'(err_underflow), 83'd1);
        chk("t5_infl", 83'(inflight), 83'd0);
        chk("t5_fwd", 83'(out_d_bits), 83'(ackd_beat));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("t5_sticky", 83'(err_underflow), 83'd1);

        // Asynchronous reset with both queues full and three beats in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, rand_a(), 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, rand_a(), 1'b0, 1'b1, rand_d(), 1'b0);
        step(1'b1, rand_a(), 1'b0, 1'b1, rand_d(), 1'b0);
        step(1'b1, rand_a(), 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, rand_a(), 1'b0, 1'b0, '0, 1'b0);
        chk("t6_pre_infl", 83'(inflight), 83'd3);
        chk("t6_pre_aready", 83'(in_a_ready), 83'd0);
        chk("t6_pre_dready", 83'(in_d_ready), 83'd0);
        drive_idle();
        reset_n = 1'b0;
        #1;
        chk("t6_a_valid", 83'(out_a_valid), 83'd0);
        chk("t6_d_valid", 83'(out_d_valid), 83'd0);
        chk("t6_infl", 83'(inflight), 83'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("t6_idle", 83'(idle), 83'd1);

        // Random traffic; D is mostly offered only when something is outstanding.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic dv;
            dv = ((infl > 0) || ($urandom_range(0, 199) == 0)) && ($urandom_range(0, 2) != 0);
            step(1'($urandom_range(0, 3) != 0), rand_a(), 1'($urandom_range(0, 3) != 0),
                 dv, rand_d(), 1'($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
